bp_btb_gshare: RTL and testbench

//  Parametrised branch predictor for the pipelined core: direct-mapped BTB (tag+target)

---
 rtl/bp_btb_gshare.sv | 114 +++++++++++
 tb/tb_bp_btb_gshare.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_btb_gshare.sv
// Direct-mapped BTB with a separate saturating-counter PHT, optionally gshare-indexed.
// Same-cycle combinational lookup on the fetch PC; resolved branches update on the clock edge.
module bp_btb_gshare #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int GSHARE  = 0,
  parameter int GHR_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pcf,
  output logic             bp_taken,
  output logic [31:0]      bp_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_mispredict,
  input  logic             inv_all,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_WNT = {CTR_W{1'b1}} >> 1;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [31:0]        r_tgt [ENTRIES];
  logic [CTR_W-1:0]   r_pht [ENTRIES];
  logic [GHR_W-1:0]   r_ghr;
  logic [CNT_W-1:0]   r_cnt;

  logic [IDX_W-1:0] w_lk_bidx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_lk_pidx;
  logic [IDX_W-1:0] w_up_bidx;
  logic [TAG_W-1:0] w_up_tag;
  logic [IDX_W-1:0] w_up_pidx;
  logic [IDX_W-1:0] w_ghr_ext;
  logic [GHR_W-1:0] w_ghr_nxt;
  logic [CTR_W-1:0] w_lk_ctr;
  logic [CTR_W-1:0] w_ctr_old;
  logic [CTR_W-1:0] w_ctr_new;
  logic             w_hit;
  logic             w_upd;
  logic             w_unused;

  assign w_lk_bidx = pcf[IDX_W+1:2];
  assign w_lk_tag  = pcf[31:IDX_W+2];
  assign w_up_bidx = upd_pc[IDX_W+1:2];
  assign w_up_tag  = upd_pc[31:IDX_W+2];
  assign w_unused  = ^{pcf[1:0], upd_pc[1:0]};

  assign w_ghr_ext = IDX_W'(r_ghr);
  assign w_lk_pidx = (GSHARE != 0) ? (w_lk_bidx ^ w_ghr_ext) : w_lk_bidx;
  assign w_up_pidx = (GSHARE != 0) ? (w_up_bidx ^ w_ghr_ext) : w_up_bidx;
  // Truncating the concatenation drops the oldest bit, also valid for GHR_W=1.
  assign w_ghr_nxt = GHR_W'({r_ghr, upd_taken});

  assign w_hit     = r_valid[w_lk_bidx] && (r_tag[w_lk_bidx] == w_lk_tag);
  assign w_lk_ctr  = r_pht[w_lk_pidx];
  assign bp_taken  = w_hit & w_lk_ctr[CTR_W-1];
  assign bp_target = w_hit ? r_tgt[w_lk_bidx] : 32'b0;

  assign w_upd     = upd_valid & ~inv_all;
  assign w_ctr_old = r_pht[w_up_pidx];

  always_comb begin
    w_ctr_new = w_ctr_old;
    if (upd_taken) begin
      if (w_ctr_old != {CTR_W{1'b1}})
        w_ctr_new = w_ctr_old + CTR_W'(1);
    end else begin
      if (w_ctr_old != '0)
        w_ctr_new = w_ctr_old - CTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_ghr   <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < ENTRIES; i++)
        r_pht[i] <= CTR_WNT;
    end else begin
      if (inv_all) begin
        r_valid <= '0;
        r_ghr   <= '0;
      end else if (upd_valid) begin
        r_pht[w_up_pidx] <= w_ctr_new;
        if (upd_taken)
          r_valid[w_up_bidx] <= 1'b1;
        if (GSHARE != 0)
          r_ghr <= w_ghr_nxt;
      end
      if (upd_valid && upd_mispredict && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Tag/target payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (reset && w_upd && upd_taken) begin
      r_tag[w_up_bidx] <= w_up_tag;
      r_tgt[w_up_bidx] <= upd_target;
    end
  end

  assign mispredict_cnt = r_cnt;

endmodule

// File: tb/tb_bp_btb_gshare.sv
// Bench for bp_btb_gshare: vector table plus hand sequences, checked through a queue.
module tb_bp_btb_gshare;

  logic        clk;
  logic        rst_n;

  logic        pcf, dummy;
  logic [31:0] m_pcf;
  logic        m_tk;
  logic [31:0] m_tg;
  logic        m_uv, m_ut, m_um, m_inv;
  logic [31:0] m_upc, m_utg;
  logic [3:0]  m_cnt;

  logic [31:0] g_pcf;
  logic        g_tk;
  logic [31:0] g_tg;
  logic        g_uv, g_ut, g_um, g_inv;
  logic [31:0] g_upc, g_utg;
  logic [3:0]  g_cnt;

  int checks;
  int failures;

  typedef struct {
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utg;
    bit          um;
    bit          inv;
    logic [31:0] pc;
    bit          etk;
    logic [31:0] etg;
    logic [3:0]  ecnt;
  } vec_t;

  typedef struct {
    string       nm;
    bit          tk;
    logic [31:0] tg;
    logic [3:0]  cnt;
  } exp_t;

  vec_t tv[$];
  exp_t sbq[$];

  bp_btb_gshare #(.ENTRIES(16), .CTR_W(2), .GSHARE(0), .GHR_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset(rst_n), .pcf(m_pcf),
    .bp_taken(m_tk), .bp_target(m_tg),
    .upd_valid(m_uv), .upd_pc(m_upc), .upd_taken(m_ut),
    .upd_target(m_utg), .upd_mispredict(m_um), .inv_all(m_inv),
    .mispredict_cnt(m_cnt)
  );

  bp_btb_gshare #(.ENTRIES(16), .CTR_W(2), .GSHARE(1), .GHR_W(2), .CNT_W(4)) dut_g (
    .clk(clk), .reset(rst_n), .pcf(g_pcf),
    .bp_taken(g_tk), .bp_target(g_tg),
    .upd_valid(g_uv), .upd_pc(g_upc), .upd_taken(g_ut),
    .upd_target(g_utg), .upd_mispredict(g_um), .inv_all(g_inv),
    .mispredict_cnt(g_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t V(bit uv, logic [31:0] upc, bit ut,
                             logic [31:0] utg, bit um, bit inv,
                             logic [31:0] pc, bit etk,
                             logic [31:0] etg, int ecnt);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg; v.um = um;
    v.inv = inv; v.pc = pc; v.etk = etk; v.etg = etg;
    v.ecnt = 4'(ecnt);
    return v;
  endfunction

  function automatic vec_t L(logic [31:0] pc, bit etk,
                             logic [31:0] etg, int ecnt);
    return V(0, 32'h0, 0, 32'h0, 0, 0, pc, etk, etg, ecnt);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input bit tk,
                          input logic [31:0] tg, input logic [3:0] cnt);
    exp_t e;
    e.nm = nm; e.tk = tk; e.tg = tg; e.cnt = cnt;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input logic tk, input logic [31:0] tg,
                         input logic [3:0] cnt);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sbq_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      cmp({e.nm, "_taken"}, 32'(tk), 32'(e.tk));
      cmp({e.nm, "_target"}, tg, e.tg);
      cmp({e.nm, "_cnt"}, 32'(cnt), 32'(e.cnt));
    end
  endtask

  task automatic idle_all();
    m_uv = 0; m_upc = 0; m_ut = 0; m_utg = 0; m_um = 0; m_inv = 0;
    g_uv = 0; g_upc = 0; g_ut = 0; g_utg = 0; g_um = 0; g_inv = 0;
  endtask

  // Inputs land 1 unit after posedge; outputs sampled on the negedge.
  task automatic step(input bit g, input vec_t v, input string nm);
    idle_all();
    if (g) begin
      g_uv = v.uv; g_upc = v.upc; g_ut = v.ut; g_utg = v.utg;
      g_um = v.um; g_inv = v.inv; g_pcf = v.pc;
    end else begin
      m_uv = v.uv; m_upc = v.upc; m_ut = v.ut; m_utg = v.utg;
      m_um = v.um; m_inv = v.inv; m_pcf = v.pc;
    end
    push_exp(nm, v.etk, v.etg, v.ecnt);
    @(negedge clk);
    if (g) pop_cmp(g_tk, g_tg, g_cnt);
    else   pop_cmp(m_tk, m_tg, m_cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    pcf = 0; dummy = 0;
    rst_n = 1'b0;
    m_pcf = 32'h100;
    g_pcf = 32'h0;
    idle_all();

    tv.push_back(L(32'h100, 0, 32'h0, 0));
    tv.push_back(V(1, 32'h40, 1, 32'h80, 0, 0, 32'h40, 0, 32'h0, 0));
    tv.push_back(L(32'h40, 1, 32'h80, 0));
    tv.push_back(V(1, 32'h40, 0, 32'h0, 0, 0, 32'h40, 1, 32'h80, 0));
    tv.push_back(V(1, 32'h40, 0, 32'h0, 0, 0, 32'h40, 0, 32'h80, 0));
    tv.push_back(V(1, 32'h40, 0, 32'h0, 0, 0, 32'h40, 0, 32'h80, 0));
    tv.push_back(V(1, 32'h40, 1, 32'h80, 0, 0, 32'h40, 0, 32'h80, 0));
    tv.push_back(V(1, 32'h40, 1, 32'h80, 0, 0, 32'h40, 0, 32'h80, 0));
    tv.push_back(L(32'h40, 1, 32'h80, 0));
    tv.push_back(L(32'h80, 0, 32'h0, 0));
    tv.push_back(V(1, 32'h80, 1, 32'h200, 1, 0, 32'h80, 0, 32'h0, 0));
    tv.push_back(L(32'h40, 0, 32'h0, 1));
    tv.push_back(L(32'h80, 1, 32'h200, 1));
    tv.push_back(V(1, 32'h44, 1, 32'h10, 0, 0, 32'h44, 0, 32'h0, 1));
    tv.push_back(L(32'h44, 1, 32'h10, 1));
    tv.push_back(V(1, 32'h48, 0, 32'h999, 0, 0, 32'h48, 0, 32'h0, 1));
    tv.push_back(L(32'h48, 0, 32'h0, 1));
    tv.push_back(V(0, 32'h48, 1, 32'h30, 1, 0, 32'h48, 0, 32'h0, 1));
    tv.push_back(L(32'h48, 0, 32'h0, 1));
    tv.push_back(V(1, 32'h4C, 1, 32'h50, 1, 1, 32'h80, 1, 32'h200, 1));
    tv.push_back(L(32'h80, 0, 32'h0, 2));
    tv.push_back(L(32'h44, 0, 32'h0, 2));
    tv.push_back(L(32'h4C, 0, 32'h0, 2));
    tv.push_back(V(1, 32'h44, 1, 32'h10, 0, 0, 32'h44, 0, 32'h0, 2));
    tv.push_back(V(1, 32'h44, 0, 32'h0, 0, 0, 32'h44, 1, 32'h10, 2));
    tv.push_back(L(32'h44, 1, 32'h10, 2));
    tv.push_back(V(1, 32'h4C, 1, 32'h50, 0, 0, 32'h4C, 0, 32'h0, 2));
    tv.push_back(V(1, 32'h4C, 0, 32'h0, 0, 0, 32'h4C, 1, 32'h50, 2));
    tv.push_back(L(32'h4C, 0, 32'h50, 2));

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tv[i])
      step(0, tv[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++)
      step(0, V(1, 32'h48, 0, 32'h0, 1, 0, 32'h48, 0, 32'h0,
                (2 + i > 15) ? 15 : 2 + i),
           $sformatf("sat%0d", i));
    step(0, L(32'h48, 0, 32'h0, 15), "sat_hold");

    step(1, V(1, 32'h40, 1, 32'h80, 0, 0, 32'h40, 0, 32'h0, 0), "gs1");
    step(1, V(1, 32'h40, 1, 32'h80, 0, 0, 32'h40, 0, 32'h80, 0), "gs2");
    step(1, L(32'h40, 0, 32'h80, 0), "gs_pidx3");
    step(1, V(1, 32'h40, 1, 32'h80, 0, 0, 32'h40, 0, 32'h80, 0), "gs4");
    step(1, L(32'h40, 1, 32'h80, 0), "gs_pidx3_tk");

    idle_all();
    m_pcf = 32'h44;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp("async_rst", 0, 32'h0, 4'h0);
    pop_cmp(m_tk, m_tg, m_cnt);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, V(1, 32'h44, 1, 32'h10, 0, 0, 32'h44, 0, 32'h0, 0), "post_rst1");
    step(0, L(32'h44, 1, 32'h10, 0), "post_rst_wnt");

    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sbq_left: got %0d entries expected 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
